prio_encoder_pipe: RTL and testbench
====================================

PRIO_ENCODER_PIPE -- requirements
Module: prio_encoder_pipe

Interface
REQ-001 SHALL have parameter N, default 8: number of request lines, legal range 2..64.
REQ-002 SHALL have parameter RR_MODE, default 0: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-003 SHALL derive local constant W = clog2(N), the index width.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port en, input, 1: enable; 0 blocks capture of new requests.
REQ-007 SHALL have port req, input, N: request vector, bit i = request from source i.
REQ-008 SHALL have port req_valid, input, 1: req is valid this cycle.
REQ-009 SHALL have port req_ready, output, 1: block accepts req this cycle.
REQ-010 SHALL have port idx, output, W: encoded index of the winning request.
REQ-011 SHALL have port any, output, 1: at least one bit was set in the captured req.
REQ-012 SHALL have port out_valid, output, 1: idx and any are valid.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts idx and any.

Function
REQ-014 SHALL assert req_ready = en AND (NOT out_valid OR out_ready), combinationally.
REQ-015 SHALL capture on req_valid AND req_ready; idx, any and out_valid=1 are registered with 1-cycle latency.
REQ-016 SHALL hold idx, any and out_valid stable while out_valid=1 and out_ready=0.
REQ-017 SHALL clear out_valid after a cycle with out_valid AND out_ready unless a new capture occurs in the same cycle.
REQ-018 SHALL support a simultaneous drain and capture in the same cycle, sustaining one result per cycle.
REQ-019 Fixed mode SHALL set idx to the highest set bit index of req.
REQ-020 Round-robin mode SHALL keep a W-bit pointer ptr; priority order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
REQ-021 Round-robin mode SHALL update ptr to (idx-1) mod N on each capture with any=1, making the granted source lowest priority next time.
REQ-022 SHALL leave ptr unchanged on a capture with req=0 and when no capture occurs.
REQ-023 SHALL produce idx=0 and any=0, with out_valid=1, when the captured req is all zero.
REQ-024 en=0 SHALL NOT affect a pending output: out_valid still drains on out_ready.
REQ-025 In fixed mode, ptr SHALL be absent or constant, with no effect on outputs.

Reset
REQ-026 rst SHALL take priority over all other inputs, including mid-transfer.
REQ-027 On rst, the block SHALL set out_valid=0, idx=0, any=0 and ptr=N-1, so the first round-robin result matches fixed priority.
REQ-028 Any pending result SHALL be discarded by rst, with no drain required.

Structure
REQ-029 A shared package SHALL hold the clog2 function and the RR_MODE encoding constants (MODE_FIXED=0, MODE_RR=1).
REQ-030 A combinational sub-module pri_find SHALL return the highest set bit index and an any flag for an N-bit vector.
REQ-031 Round-robin SHALL use two pri_find instances: one on req masked to indices <= ptr, and one on unmasked req as fallback.
REQ-032 The top level SHALL contain only the handshake register stage and the ptr register.

Verification
REQ-033 Fixed, N=8: req=8'b0010_0110, req_valid=1, out_ready=1 -> next cycle idx=5, any=1, out_valid=1.
REQ-034 Fixed: req=8'h00 captured -> idx=0, any=0, out_valid=1; then req=8'h01 -> idx=0, any=1.
REQ-035 RR, N=8, after reset: req=8'hFF for 4 consecutive captures -> idx 7, 6, 5, 4; then req=8'b1000_0001 repeated -> idx 0, 7, 0, 7.
REQ-036 Backpressure: capture 8'h10, hold out_ready=0 for 3 cycles with req_valid=1 and req=8'h02 -> idx=4 held, req_ready=0; on out_ready=1 the 8'h02 request is captured that cycle and idx=1 follows.
REQ-037 en=0 with req_valid=1 and req=8'h80 for 2 cycles -> req_ready=0, no new out_valid; after en=1 -> idx=7.
REQ-038 RR, rst asserted while out_valid=1 and ptr=3 -> next cycle out_valid=0, idx=0; then req=8'hFF -> idx=7.

Source files
------------

// File: rtl/prio_encoder_pipe_pkg.sv
// Shared definitions for the pipelined priority encoder.
//   clog2      - ceiling log2, used to size the index outputs.
//   MODE_FIXED - RR_MODE value for fixed priority (highest index wins).
//   MODE_RR    - RR_MODE value for round-robin priority.
package prio_encoder_pipe_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    // Smallest r with 2**r >= v; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_encoder_pipe_pri_find.sv
// pri_find: combinational highest-set-bit finder.
//   vec - N-bit input vector
//   idx - index of the highest set bit of vec (0 when vec is all zero)
//   any - 1 when at least one bit of vec is set
module pri_find #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_encoder_pipe.sv
// prio_encoder_pipe: priority encoder with a one-deep valid/ready output stage.
//   clk       - clock, all state on the rising edge
//   rst       - synchronous active-high reset
//   en        - enable; 0 blocks capture of new requests (draining still works)
//   req       - N-bit request vector
//   req_valid - req is valid this cycle
//   req_ready - block accepts req this cycle
//   idx       - registered index of the winning request
//   any       - registered flag: captured req had at least one bit set
//   out_valid - idx/any hold a result
//   out_ready - downstream accepts idx/any
// RR_MODE selects fixed priority (highest index wins) or round-robin.
module prio_encoder_pipe
    import prio_encoder_pipe_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned RR_MODE = MODE_FIXED,
    localparam int unsigned W      = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         req_valid,
    output logic         req_ready,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         capture;
    logic [W-1:0] win_idx;
    logic         win_any;

    // Accept when the stage is empty or is being drained this cycle.
    assign req_ready = en & (~out_valid | out_ready);
    assign capture   = req_valid & req_ready;

    if (RR_MODE == MODE_RR) begin : g_rr
        logic [W-1:0] ptr;
        logic [N-1:0] mask;
        logic [W-1:0] m_idx;
        logic [W-1:0] u_idx;
        logic         m_any;
        logic         u_any;

        always_comb begin
            mask = '0;
            for (int i = 0; i < N; i++) begin
                mask[i] = (W'(i) <= ptr);
            end
        end

        // Masked search covers ptr..0; if empty, the unmasked highest bit
        // is necessarily above ptr, giving the N-1..ptr+1 wraparound.
        pri_find #(.N(N), .W(W)) u_masked (
            .vec (req & mask),
            .idx (m_idx),
            .any (m_any)
        );

        pri_find #(.N(N), .W(W)) u_full (
            .vec (req),
            .idx (u_idx),
            .any (u_any)
        );

        assign win_idx = m_any ? m_idx : u_idx;
        assign win_any = u_any;

        // Granted source becomes lowest priority next time.
        always_ff @(posedge clk) begin
            if (rst) begin
                ptr <= W'(N - 1);
            end else if (capture && win_any) begin
                ptr <= (win_idx == '0) ? W'(N - 1) : win_idx - 1'b1;
            end
        end
    end else begin : g_fixed
        pri_find #(.N(N), .W(W)) u_full (
            .vec (req),
            .idx (win_idx),
            .any (win_any)
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            idx       <= '0;
            any       <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            idx       <= win_idx;
            any       <= win_any;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prio_encoder_pipe.sv
module tb_prio_encoder_pipe;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       req_valid;
    logic       out_ready;

    logic       f_req_ready, f_any, f_out_valid;
    logic [2:0] f_idx;
    logic       r_req_ready, r_any, r_out_valid;
    logic [2:0] r_idx;

    int tests;
    int fails;

    prio_encoder_pipe #(.N(8), .RR_MODE(0)) u_fix (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .req_valid (req_valid),
        .req_ready (f_req_ready),
        .idx       (f_idx),
        .any       (f_any),
        .out_valid (f_out_valid),
        .out_ready (out_ready)
    );

    prio_encoder_pipe #(.N(8), .RR_MODE(1)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .req_valid (req_valid),
        .req_ready (r_req_ready),
        .idx       (r_idx),
        .any       (r_any),
        .out_valid (r_out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rr_exp[8];
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        en        = 1'b1;
        req       = 8'h00;
        req_valid = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();

        // Reset state
        chk("rst_f_ov", {7'd0, f_out_valid}, 8'd0);
        chk("rst_f_idx", {5'd0, f_idx}, 8'd0);
        chk("rst_f_any", {7'd0, f_any}, 8'd0);
        chk("rst_r_ov", {7'd0, r_out_valid}, 8'd0);
        chk("rst_r_idx", {5'd0, r_idx}, 8'd0);
        chk("rst_f_rdy", {7'd0, f_req_ready}, 8'd1);

        // Fixed: highest set bit of 0010_0110 is 5
        rst = 1'b0; req = 8'b0010_0110; req_valid = 1'b1;
        cyc();
        chk("fx_26_idx", {5'd0, f_idx}, 8'd5);
        chk("fx_26_any", {7'd0, f_any}, 8'd1);
        chk("fx_26_ov", {7'd0, f_out_valid}, 8'd1);

        // Fixed: zero request still produces a valid result
        req = 8'h00;
        cyc();
        chk("fx_00_idx", {5'd0, f_idx}, 8'd0);
        chk("fx_00_any", {7'd0, f_any}, 8'd0);
        chk("fx_00_ov", {7'd0, f_out_valid}, 8'd1);
        req = 8'h01;
        cyc();
        chk("fx_01_idx", {5'd0, f_idx}, 8'd0);
        chk("fx_01_any", {7'd0, f_any}, 8'd1);

        // Drain with no new request
        req_valid = 1'b0;
        cyc();
        chk("fx_drain_ov", {7'd0, f_out_valid}, 8'd0);

        // Backpressure
        req = 8'h10; req_valid = 1'b1;
        cyc();
        chk("bp_cap_idx", {5'd0, f_idx}, 8'd4);
        out_ready = 1'b0; req = 8'h02;
        #1;
        chk("bp_rdy0", {7'd0, f_req_ready}, 8'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp_hold_idx", {5'd0, f_idx}, 8'd4);
            chk("bp_hold_ov", {7'd0, f_out_valid}, 8'd1);
            chk("bp_hold_rdy", {7'd0, f_req_ready}, 8'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rdy1", {7'd0, f_req_ready}, 8'd1);
        cyc();
        chk("bp_next_idx", {5'd0, f_idx}, 8'd1);
        chk("bp_next_ov", {7'd0, f_out_valid}, 8'd1);
        req_valid = 1'b0;
        cyc();
        chk("bp_drain_ov", {7'd0, f_out_valid}, 8'd0);

        // Enable low blocks capture
        en = 1'b0; req = 8'h80; req_valid = 1'b1;
        #1;
        chk("en0_rdy", {7'd0, f_req_ready}, 8'd0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("en0_ov", {7'd0, f_out_valid}, 8'd0);
            chk("en0_rdy_h", {7'd0, f_req_ready}, 8'd0);
        end
        en = 1'b1;
        cyc();
        chk("en1_idx", {5'd0, f_idx}, 8'd7);
        chk("en1_ov", {7'd0, f_out_valid}, 8'd1);

        // Enable low still lets a pending result drain
        en = 1'b0; req_valid = 1'b0;
        cyc();
        chk("en0_drain_ov", {7'd0, f_out_valid}, 8'd0);

        // Round-robin from reset
        rst = 1'b1; en = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rr_rst_ov", {7'd0, r_out_valid}, 8'd0);
        rr_exp = '{7, 6, 5, 4, 0, 7, 0, 7};
        req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req = (k < 4) ? 8'hFF : 8'b1000_0001;
            cyc();
            chk("rr_seq_idx", {5'd0, r_idx}, 8'(rr_exp[k]));
            chk("rr_seq_ov", {7'd0, r_out_valid}, 8'd1);
            chk("fx_seq_idx", {5'd0, f_idx}, 8'd7);
        end

        // Walk ptr down to 3: grants 6, 5, 4
        req = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rr_walk_idx", {5'd0, r_idx}, 8'(6 - k));
        end

        // Reset mid-transfer discards the pending result and restores ptr
        rst = 1'b1;
        cyc();
        chk("rr_midrst_ov", {7'd0, r_out_valid}, 8'd0);
        chk("rr_midrst_idx", {5'd0, r_idx}, 8'd0);
        chk("rr_midrst_any", {7'd0, r_any}, 8'd0);
        rst = 1'b0;
        cyc();
        chk("rr_postrst_idx", {5'd0, r_idx}, 8'd7);
        chk("rr_postrst_ov", {7'd0, r_out_valid}, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
